door_controller: RTL and testbench

Parametrised door controller for one car of the two-way elevator. It succeeds the single-speed open/close door with a four-phase door model:
- door travel time
- reversal on obstruction
- nudge mode after repeated reopenings
- a separate `moving` input instead of using reset as the motion detector

It sits between the floor/direction logic and the car motion controller. It reports door status and a one-cycle `served` pulse that clears the answered call.

---
 rtl/elevator_pkg.sv | 30 +++
 rtl/door_controller_if.sv | 33 +++
 rtl/door_timer.sv | 33 +++
 rtl/door_controller.sv | 159 +++++++++++++++
 tb/tb_door_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction codes, hall button bit positions,
// door state encoding and car-button index helpers.
package elevator_pkg;

   typedef enum logic [1:0] {
      DIR_STOP = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_e;

   localparam int unsigned HALL_UP_BIT   = 0;
   localparam int unsigned HALL_DOWN_BIT = 1;

   typedef enum logic [1:0] {
      DOOR_CLOSED,
      DOOR_OPENING,
      DOOR_OPEN,
      DOOR_CLOSING
   } door_state_e;

   // Car button vector is [floors+2:1]: floors first, then CLOSE, then OPEN.
   function automatic int unsigned close_b_idx(input int unsigned floors);
      return floors + 1;
   endfunction

   function automatic int unsigned open_b_idx(input int unsigned floors);
      return floors + 2;
   endfunction

endpackage

// File: rtl/door_controller_if.sv
// Door controller bus: car/floor status and buttons toward the door,
// door status back to the motion controller.
//   master: drives moving, floor, direction, buttons, obstruct; reads status
//   slave : the door controller
interface door_controller_if #(
   parameter int unsigned FLOORS = 7
);
   localparam int unsigned FLW = $clog2(FLOORS + 1);

   logic                  moving;
   logic [FLW-1:0]        currentFloor;
   logic [1:0]            currentDirection;
   logic [1:0]            currentFloorButton;
   logic [FLOORS+2:1]     internalButton;
   logic                  obstruct;
   logic                  doorState;
   logic                  doorClosed;
   logic                  nudge;
   logic                  served;
   logic                  doorFault;

   modport master (
      output moving, currentFloor, currentDirection, currentFloorButton,
             internalButton, obstruct,
      input  doorState, doorClosed, nudge, served, doorFault
   );

   modport slave (
      input  moving, currentFloor, currentDirection, currentFloorButton,
             internalButton, obstruct,
      output doorState, doorClosed, nudge, served, doorFault
   );
endinterface

// File: rtl/door_timer.sv
// Loadable down-counter used for the door dwell time.
//   load  : reload to MAX (highest priority)
//   clear : force to zero
//   hold  : keep the current value (otherwise decrement, stopping at zero)
//   zero_c: counter value after this edge will be zero
module door_timer #(
   parameter int unsigned MAX = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   input  logic hold,
   output logic zero_c
);
   localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)                        cnt_d = CW'(MAX);
      else if (clear)                  cnt_d = '0;
      else if (!hold && cnt_q != '0)   cnt_d = cnt_q - CW'(1);
   end

   assign zero_c = (cnt_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/door_controller.sv
// Four-phase car door controller with travel time, obstruction reversal,
// nudge mode after repeated reopenings and a sticky fault when the car
// moves with the door not closed.
//   clk, reset (async, active low)
//   bus: door_controller_if.slave (inputs from car logic, door status out)
module door_controller
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS         = 7,
   parameter int unsigned CLK_PER_OPEN   = 500000000,
   parameter int unsigned CLK_PER_TRAVEL = 50000000,
   parameter int unsigned MAX_REOPEN     = 3
) (
   input  logic             clk,
   input  logic             reset,
   door_controller_if.slave bus
);
   localparam int unsigned FLW      = $clog2(FLOORS + 1);
   localparam int unsigned POS_W    = (CLK_PER_TRAVEL < 1) ? 1 : $clog2(CLK_PER_TRAVEL + 1);
   localparam int unsigned REOPEN_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);
   localparam int unsigned OPEN_IDX  = open_b_idx(FLOORS);
   localparam int unsigned CLOSE_IDX = close_b_idx(FLOORS);

   door_state_e         state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [REOPEN_W-1:0] reopen_q, reopen_d, reopen_inc;
   logic nudge_q, nudge_d, half_q, half_d, fault_q, fault_d, served_q, served_d;
   logic door_state_q, door_closed_q;

   logic [FLOORS:1] floor_hit;
   logic hit_hall_c, call_c, open_raw_c, open_eff_c, close_eff_c, reverse_c;
   logic nudge_apply_c, freeze_c, step_ok_c, open_reach_c;
   logic t_load, t_clear, t_hold, dwell_zero_c;

   // Car button for the floor the car is standing at.
   for (genvar g = 1; g <= FLOORS; g++) begin : g_floor
      assign floor_hit[g] = (bus.currentFloor == FLW'(g)) && bus.internalButton[g];
   end

   // Hall call only counts when it agrees with the travel direction.
   assign hit_hall_c = (bus.currentDirection == DIR_UP   && bus.currentFloorButton[HALL_UP_BIT]) ||
                       (bus.currentDirection == DIR_DOWN && bus.currentFloorButton[HALL_DOWN_BIT]);

   assign call_c      = !bus.moving && (hit_hall_c || (|floor_hit));
   assign open_raw_c  = !bus.moving && bus.internalButton[OPEN_IDX];
   assign open_eff_c  = open_raw_c && !nudge_q;
   assign close_eff_c = !bus.moving && bus.internalButton[CLOSE_IDX] && !nudge_q;
   assign reverse_c   = !bus.moving && !nudge_q && (bus.obstruct || open_raw_c || call_c);

   // Nudge rules are suspended while the car moves (forced close).
   assign nudge_apply_c = nudge_q && !bus.moving;
   assign freeze_c      = nudge_apply_c && bus.obstruct && (state_q == DOOR_CLOSING);
   assign step_ok_c     = !nudge_apply_c || half_q;
   assign open_reach_c  = (state_q == DOOR_OPENING) && !bus.moving &&
                          ((pos_q >= POS_W'(CLK_PER_TRAVEL)) ||
                           (step_ok_c && pos_q == POS_W'(CLK_PER_TRAVEL - 1)));

   assign reopen_inc = (reopen_q >= REOPEN_W'(MAX_REOPEN)) ? reopen_q : reopen_q + REOPEN_W'(1);

   // Dwell timer controls: OPEN_B beats CLOSE_B, obstruction holds.
   always_comb begin
      t_load  = open_reach_c || (state_q == DOOR_OPEN && open_eff_c);
      t_clear = (state_q == DOOR_OPEN) && !open_eff_c && close_eff_c;
      t_hold  = (state_q != DOOR_OPEN) || bus.obstruct || bus.moving;
   end

   door_timer #(.MAX(CLK_PER_OPEN)) u_dwell (
      .clk    (clk),
      .rst_n  (reset),
      .load   (t_load),
      .clear  (t_clear),
      .hold   (t_hold),
      .zero_c (dwell_zero_c)
   );

   // Next-state and counter update.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      reopen_d = reopen_q;
      nudge_d  = nudge_q;
      half_d   = 1'b0;
      fault_d  = fault_q | (bus.moving && state_q != DOOR_CLOSED);
      served_d = 1'b0;

      if (nudge_apply_c && !freeze_c &&
          (state_q == DOOR_OPENING || state_q == DOOR_CLOSING))
         half_d = !half_q;

      case (state_q)
         DOOR_CLOSED: begin
            if (call_c || open_raw_c) begin
               state_d  = DOOR_OPENING;
               served_d = call_c;
               reopen_d = '0;
               nudge_d  = 1'b0;
            end
         end
         DOOR_OPENING: begin
            if (bus.moving) begin
               state_d = DOOR_CLOSING;
            end else begin
               if (pos_q < POS_W'(CLK_PER_TRAVEL) && step_ok_c) pos_d = pos_q + POS_W'(1);
               if (open_reach_c) state_d = DOOR_OPEN;
            end
         end
         DOOR_OPEN: begin
            if (bus.moving || (dwell_zero_c && !bus.obstruct)) state_d = DOOR_CLOSING;
         end
         DOOR_CLOSING: begin
            if (reverse_c) begin
               state_d  = DOOR_OPENING;
               reopen_d = reopen_inc;
               if (reopen_inc == REOPEN_W'(MAX_REOPEN)) nudge_d = 1'b1;
            end else if (pos_q == '0) begin
               state_d = DOOR_CLOSED;
               nudge_d = 1'b0;
            end else if (step_ok_c && !freeze_c) begin
               pos_d = pos_q - POS_W'(1);
               if (pos_q == POS_W'(1)) begin
                  state_d = DOOR_CLOSED;
                  nudge_d = 1'b0;
               end
            end
         end
         default: state_d = DOOR_CLOSED;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= DOOR_CLOSED;
         pos_q         <= '0;
         reopen_q      <= '0;
         nudge_q       <= 1'b0;
         half_q        <= 1'b0;
         fault_q       <= 1'b0;
         served_q      <= 1'b0;
         door_state_q  <= 1'b0;
         door_closed_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         pos_q         <= pos_d;
         reopen_q      <= reopen_d;
         nudge_q       <= nudge_d;
         half_q        <= half_d;
         fault_q       <= fault_d;
         served_q      <= served_d;
         door_state_q  <= (state_d != DOOR_CLOSED);
         door_closed_q <= (state_d == DOOR_CLOSED);
      end
   end

   assign bus.doorState  = door_state_q;
   assign bus.doorClosed = door_closed_q;
   assign bus.nudge      = nudge_q;
   assign bus.served     = served_q;
   assign bus.doorFault  = fault_q;
endmodule

// File: tb/tb_door_controller.sv
// Scoreboard bench for door_controller: stimulus pushes the reference
// model's expected outputs, a monitor pops and compares every cycle.
module tb_door_controller;
   localparam int FLOORS = 7;
   localparam int TRAVEL = 4;
   localparam int DWELL  = 6;
   localparam int MAXR   = 2;
   localparam int FLW    = $clog2(FLOORS + 1);
   localparam int IBW    = FLOORS + 2;

   localparam int PH_SHUT    = 0;
   localparam int PH_OPENING = 1;
   localparam int PH_OPEN    = 2;
   localparam int PH_CLOSING = 3;

   typedef struct packed {
      logic door_state;
      logic door_closed;
      logic nudge;
      logic served;
      logic fault;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   door_controller_if #(.FLOORS(FLOORS)) bus ();

   door_controller #(
      .FLOORS         (FLOORS),
      .CLK_PER_OPEN   (DWELL),
      .CLK_PER_TRAVEL (TRAVEL),
      .MAX_REOPEN     (MAXR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // staged stimulus, applied at the next falling edge
   logic           s_rst;
   logic           s_moving;
   logic [FLW-1:0] s_floor;
   logic [1:0]     s_dir;
   logic [1:0]     s_hall;
   logic [IBW:1]   s_ib;
   logic           s_obs;

   // reference model of the door
   int m_phase, m_pos, m_dwell, m_reopen, m_slow;
   bit m_nudge, m_fault, m_served;

   function automatic void model_reset();
      m_phase = PH_SHUT; m_pos = 0; m_dwell = 0; m_reopen = 0; m_slow = 0;
      m_nudge = 0; m_fault = 0; m_served = 0;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.door_state  = (m_phase != PH_SHUT);
      e.door_closed = (m_phase == PH_SHUT);
      e.nudge       = m_nudge;
      e.served      = m_served;
      e.fault       = m_fault;
      return e;
   endfunction

   function automatic void model_step();
      bit hall_hit, car_hit, call, obtn, cbtn, slow, frozen, moves;
      logic [IBW:0] sh;
      sh       = {s_ib, 1'b0} >> s_floor;
      hall_hit = (s_dir == 2'b01 || s_dir == 2'b10) && ((s_dir & s_hall) != 2'b00);
      car_hit  = (s_floor != '0) && (int'(s_floor) <= FLOORS) && sh[0];
      call     = !s_moving && (hall_hit || car_hit);
      obtn     = !s_moving && s_ib[FLOORS+2];
      cbtn     = !s_moving && s_ib[FLOORS+1];
      slow     = m_nudge && !s_moving;
      frozen   = slow && m_phase == PH_CLOSING && s_obs;
      if (slow && !frozen && (m_phase == PH_OPENING || m_phase == PH_CLOSING)) begin
         m_slow++;
         moves = (m_slow % 2 == 0);
      end else begin
         m_slow = 0;
         moves  = !slow;
      end
      m_served = 0;
      if (s_moving && m_phase != PH_SHUT) m_fault = 1;
      case (m_phase)
         PH_SHUT: if (call || obtn) begin
            m_phase = PH_OPENING; m_served = call; m_reopen = 0; m_nudge = 0;
         end
         PH_OPENING: if (s_moving) m_phase = PH_CLOSING;
         else begin
            if (m_pos < TRAVEL && moves) m_pos++;
            if (m_pos == TRAVEL) begin m_phase = PH_OPEN; m_dwell = DWELL; end
         end
         PH_OPEN: if (s_moving) m_phase = PH_CLOSING;
         else begin
            if (obtn && !m_nudge)            m_dwell = DWELL;
            else if (cbtn && !m_nudge)       m_dwell = 0;
            else if (!s_obs && m_dwell > 0)  m_dwell--;
            if (m_dwell == 0 && !s_obs) m_phase = PH_CLOSING;
         end
         default: begin
            if (!s_moving && !m_nudge && (s_obs || obtn || call)) begin
               m_phase = PH_OPENING;
               if (m_reopen < MAXR) m_reopen++;
               if (m_reopen == MAXR) m_nudge = 1;
            end else begin
               if (m_pos > 0 && moves && !frozen) m_pos--;
               if (m_pos == 0) begin m_phase = PH_SHUT; m_nudge = 0; end
            end
         end
      endcase
   endfunction

   function automatic exp_t sample();
      exp_t a;
      a.door_state  = bus.doorState;
      a.door_closed = bus.doorClosed;
      a.nudge       = bus.nudge;
      a.served      = bus.served;
      a.fault       = bus.doorFault;
      return a;
   endfunction

   task automatic tick();
      @(negedge clk);
      reset                  = s_rst;
      bus.moving             = s_moving;
      bus.currentFloor       = s_floor;
      bus.currentDirection   = s_dir;
      bus.currentFloorButton = s_hall;
      bus.internalButton     = s_ib;
      bus.obstruct           = s_obs;
      if (!s_rst) model_reset();
      else        model_step();
      exp_q.push_back(model_out());
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic idle_inputs();
      s_moving = 0; s_floor = FLW'(3); s_dir = 2'b00; s_hall = 2'b00; s_ib = '0; s_obs = 0;
   endtask

   task automatic wait_for(input int ph, input int pos, input int limit, input string what);
      int n;
      n = 0;
      while (!(m_phase == ph && (pos < 0 || m_pos == pos)) && n < limit) begin
         tick();
         n++;
      end
      if (!(m_phase == ph && (pos < 0 || m_pos == pos))) begin
         checks++;
         errors++;
         $display("FAIL wait_%s: phase %0d pos %0d, wanted phase %0d pos %0d", what, m_phase, m_pos, ph, pos);
      end
   endtask

   task automatic press_floor3();
      s_ib = '0; s_ib[3] = 1'b1; tick(); s_ib = '0;
   endtask

   task automatic async_reset_check();
      exp_t a, e;
      @(negedge clk);
      #2;
      s_rst = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      e = model_out();
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", a, e);
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs just after each rising edge.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got {ds,dc,nudge,served,fault}=%b expected %b", $time, a, e);
            end
         end
      end
   end

   initial begin
      s_rst = 1'b0;
      idle_inputs();
      bus.moving = 0; bus.currentFloor = '0; bus.currentDirection = '0;
      bus.currentFloorButton = '0; bus.internalButton = '0; bus.obstruct = 0;
      model_reset();

      // reset state
      ticks(2);
      s_rst = 1'b1;
      ticks(2);

      // car button at floor 3: open, dwell, close
      press_floor3();
      wait_for(PH_SHUT, -1, 40, "car_close");
      ticks(2);

      // two obstruction reversals at pos 2 lead into nudge mode
      press_floor3();
      for (int r = 0; r < 2; r++) begin
         wait_for(PH_CLOSING, 2, 40, "closing_pos2");
         s_obs = 1; tick(); s_obs = 0;
         wait_for(PH_OPEN, -1, 40, "reopened");
      end
      // nudge: obstruction freezes, OPEN_B ignored, half-speed close
      wait_for(PH_CLOSING, 3, 60, "nudge_closing");
      s_obs = 1; ticks(3); s_obs = 0;
      s_ib[FLOORS+2] = 1'b1; ticks(4); s_ib = '0;
      wait_for(PH_SHUT, -1, 60, "nudge_shut");
      ticks(2);

      // OPEN_B with CLOSE_B reloads dwell; CLOSE_B alone closes
      press_floor3();
      wait_for(PH_OPEN, -1, 20, "prio_open");
      s_ib[FLOORS+2] = 1'b1; s_ib[FLOORS+1] = 1'b1; tick(); s_ib = '0;
      ticks(2);
      s_ib[FLOORS+1] = 1'b1; tick(); s_ib = '0;
      wait_for(PH_SHUT, -1, 40, "prio_shut");

      // hall call against direction is ignored, matching one opens
      s_dir = 2'b01; s_hall = 2'b10; ticks(5);
      s_dir = 2'b10; tick();
      idle_inputs();
      wait_for(PH_SHUT, -1, 40, "hall_shut");

      // moving with door open: fault and forced close, then async reset
      press_floor3();
      wait_for(PH_OPEN, -1, 20, "fault_open");
      s_moving = 1; ticks(2); s_moving = 0;
      tick();
      async_reset_check();
      ticks(2);
      s_rst = 1'b1;
      ticks(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s_rst    = ($urandom_range(0, 249) != 0);
         s_moving = ($urandom_range(0, 99) < 2);
         s_obs    = ($urandom_range(0, 99) < 10);
         s_floor  = FLW'($urandom_range(0, FLOORS));
         s_dir    = 2'($urandom);
         s_hall   = 2'($urandom) & 2'($urandom);
         s_ib     = IBW'($urandom) & IBW'($urandom) & IBW'($urandom) & IBW'($urandom);
         tick();
      end
      s_rst = 1'b1;
      idle_inputs();
      ticks(3);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
